// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin sharing of the 4-digit 7-segment display between N_SRC requesters.
// Each granted source is shown for DWELL cycles, then the next requester (searching
// upward with wrap) takes over. Source 0 may preempt on a rising request when PRIO0=1.
// All outputs are registered and reflect the decision taken at the same clock edge.
module seg_display_arbiter #(
  parameter int N_SRC = 4,
  parameter int DWELL = 100_000_000,
  parameter bit PRIO0 = 1'b1,
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      req,
  input  logic [16*N_SRC-1:0]   data,
  input  logic                  hold,
  output logic [15:0]           binary_num,
  output logic                  disp_valid,
  output logic [IW-1:0]         src_idx,
  output logic [N_SRC-1:0]      grant
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     src_q, src_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [15:0]       num_q, num_d;
  logic              valid_q, valid_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic              req0_q, req0_d;

  logic              idle_hit;
  logic [IW-1:0]     idle_idx;
  logic              next_hit;
  logic [IW-1:0]     next_idx;
  logic              req0_rise;
  logic              take_en;
  logic [IW-1:0]     take_idx;

  logic [15:0]       data_arr [N_SRC];

  // Split the flat data bus into one 16-bit word per source.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slice
      assign data_arr[gi] = data[16*gi +: 16];
    end
  endgenerate

  // Rising edge of source 0's request, only meaningful when preemption is enabled.
  assign req0_rise = PRIO0 && req[0] && !req0_q;

  // Requester searches: from the rr pointer (inclusive) for IDLE, and from the
  // source after the current one (wrapping, current excluded) for expiry/drop.
  // Loops run from the far end down so the nearest hit is the one kept.
  always_comb begin : p_search
    int            j;
    logic [IW-1:0] jj;
    j        = 0;
    jj       = '0;
    idle_hit = 1'b0;
    idle_idx = '0;
    next_hit = 1'b0;
    next_idx = src_q;
    for (int off = N_SRC - 1; off >= 0; off--) begin
      j = int'(rr_q) + off;
      if (j >= N_SRC) j = j - N_SRC;
      jj = IW'(j);
      if (req[jj]) begin
        idle_hit = 1'b1;
        idle_idx = jj;
      end
    end
    for (int off = N_SRC - 1; off >= 1; off--) begin
      j = int'(src_q) + off;
      if (j >= N_SRC) j = j - N_SRC;
      jj = IW'(j);
      if (req[jj]) begin
        next_hit = 1'b1;
        next_idx = jj;
      end
    end
  end

  // Next-state logic: drop beats preemption beats expiry beats hold; any
  // switch restarts the dwell counter, moves the rr pointer and pulses grant.
  always_comb begin : p_fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    rr_d     = rr_q;
    grant_d  = '0;
    req0_d   = req[0];
    take_en  = 1'b0;
    take_idx = '0;
    case (state_q)
      IDLE: begin
        if (idle_hit) begin
          take_en  = 1'b1;
          take_idx = idle_idx;
        end
      end
      SHOW: begin
        if (!req[src_q]) begin
          if (next_hit) begin
            take_en  = 1'b1;
            take_idx = next_idx;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (req0_rise && (src_q != '0)) begin
          take_en  = 1'b1;
          take_idx = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          // With hold asserted the counter simply sits at its last value.
          if (!hold) begin
            if (next_hit) begin
              take_en  = 1'b1;
              take_idx = next_idx;
            end else begin
              cnt_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_en) begin
      state_d = SHOW;
      src_d   = take_idx;
      rr_d    = take_idx;
      cnt_d   = '0;
      grant_d = N_SRC'(1) << take_idx;
    end
    valid_d = (state_d == SHOW);
    num_d   = (state_d == SHOW) ? data_arr[src_d] : 16'h0000;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      num_q   <= 16'h0000;
      valid_q <= 1'b0;
      grant_q <= '0;
      req0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      req0_q  <= req0_d;
    end
  end

  assign binary_num = num_q;
  assign disp_valid = valid_q;
  assign src_idx    = src_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios with literal expectations,
// then randomized requests/hold/data/reset, all cross-checked every cycle
// against a behavioural model of the display sharing rules.
module tb_seg_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk  = 1'b0;
  logic            rst  = 1'b1;
  logic [N-1:0]    req  = '0;
  logic [16*N-1:0] data = '0;
  logic            hold = 1'b0;
  logic [15:0]     binary_num;
  logic            disp_valid;
  logic [IW-1:0]   src_idx;
  logic [N-1:0]    grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .N_SRC (N),
    .DWELL (DW),
    .PRIO0 (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .hold       (hold),
    .binary_num (binary_num),
    .disp_valid (disp_valid),
    .src_idx    (src_idx),
    .grant      (grant)
  );

  logic [15:0] dwords [N];
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_words
      assign dwords[gi] = data[16*gi +: 16];
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Who is on the display, for how many cycles it has been there, where the
  // next idle search starts, and what the outputs must read.
  bit          m_live  = 1'b0;
  bit          m_show;
  int          m_src;
  int          m_time;
  int          m_rr;
  bit          m_prev0;
  logic [N-1:0] m_grant;
  logic [15:0] m_num;

  // First requesting source among start+first_off .. start+N-1 (mod N), or -1.
  function automatic int seek(input logic [N-1:0] r, input int start, input int first_off);
    for (int k = first_off; k < N; k++) begin
      if (r[IW'((start + k) % N)]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic give(input int s);
    m_show  = 1'b1;
    m_src   = s;
    m_time  = 0;
    m_rr    = s;
    m_grant = N'(1) << s;
  endtask

  always @(posedge clk) begin
    int nxt;
    m_live  = 1'b1;
    m_grant = '0;
    if (rst) begin
      m_show  = 1'b0;
      m_src   = 0;
      m_time  = 0;
      m_rr    = 0;
      m_prev0 = 1'b0;
      m_num   = 16'h0;
    end else begin
      if (!m_show) begin
        nxt = seek(req, m_rr, 0);
        if (nxt >= 0) give(nxt);
      end else if (!req[IW'(m_src)]) begin
        nxt = seek(req, m_src, 1);
        if (nxt >= 0) give(nxt);
        else begin
          m_show = 1'b0;
          m_time = 0;
        end
      end else if (req[0] && !m_prev0 && m_src != 0) begin
        give(0);
      end else if (m_time == DW - 1) begin
        if (!hold) begin
          nxt = seek(req, m_src, 1);
          if (nxt >= 0) give(nxt);
          else m_time = 0;
        end
      end else begin
        m_time++;
      end
      m_prev0 = req[0];
      m_num   = m_show ? dwords[IW'(m_src)] : 16'h0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("model_disp_valid", 32'(disp_valid), 32'(m_show));
      chk("model_binary_num", 32'(binary_num), 32'(m_num));
      chk("model_src_idx",    32'(src_idx),    32'(m_src));
      chk("model_grant",      32'(grant),      32'(m_grant));
      if (grant != '0)
        $display("grant src=%0d value=%04h t=%0t", src_idx, binary_num, $time);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = '0;
    hold = 1'b0;
    rst  = 1'b1;
    step();
    step();
    rst  = 1'b0;
  endtask

  initial begin
    int gcount;

    // Idle after reset with no requests.
    rst = 1'b1;
    step();
    chk("reset_valid", 32'(disp_valid), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_valid", 32'(disp_valid), 32'd0);
      chk("idle_num",   32'(binary_num), 32'd0);
      chk("idle_grant", 32'(grant),      32'd0);
    end

    // Rotation between sources 1 and 3.
    do_reset();
    data = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
    req  = 4'b1010;
    step();
    chk("rot_grant1", 32'(grant), 32'h2);
    chk("rot_src1",   32'(src_idx), 32'd1);
    chk("rot_num1",   32'(binary_num), 32'h1111);
    for (int i = 1; i < DW; i++) begin
      step();
      chk("rot_hold1", 32'(src_idx), 32'd1);
      chk("rot_nogr1", 32'(grant), 32'd0);
    end
    step();
    chk("rot_grant3", 32'(grant), 32'h8);
    chk("rot_src3",   32'(src_idx), 32'd3);
    chk("rot_num3",   32'(binary_num), 32'h3333);
    for (int i = 1; i < DW; i++) begin
      step();
      chk("rot_hold3", 32'(src_idx), 32'd3);
    end
    step();
    chk("rot_back1", 32'(src_idx), 32'd1);
    chk("rot_regr1", 32'(grant), 32'h2);

    // Single source, live data update, only one grant ever.
    do_reset();
    data = {16'h0000, 16'h00A0, 16'h0000, 16'h0000};
    req  = 4'b0100;
    step();
    chk("live_grant", 32'(grant), 32'h4);
    chk("live_num0",  32'(binary_num), 32'h00A0);
    step();
    step();
    data = {16'h0000, 16'h00A1, 16'h0000, 16'h0000};
    step();
    chk("live_num1", 32'(binary_num), 32'h00A1);
    chk("live_src",  32'(src_idx), 32'd2);
    gcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant != '0) gcount++;
    end
    chk("live_single_grant", 32'(gcount), 32'd0);
    chk("live_src_end", 32'(src_idx), 32'd2);

    // Current source dropping its request.
    do_reset();
    req = 4'b0110;
    step();
    chk("drop_start", 32'(src_idx), 32'd1);
    step();
    step();
    step();
    req = 4'b0100;
    step();
    chk("drop_src",   32'(src_idx), 32'd2);
    chk("drop_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    step();
    chk("drop_idle_valid", 32'(disp_valid), 32'd0);
    chk("drop_idle_num",   32'(binary_num), 32'd0);

    // Hold across expiry, then wrap to source 0.
    do_reset();
    req = 4'b0011;
    step();
    chk("hold_first", 32'(src_idx), 32'd0);
    for (int i = 1; i < DW; i++) step();
    step();
    chk("hold_src1", 32'(src_idx), 32'd1);
    chk("hold_gr1",  32'(grant), 32'h2);
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_stay", 32'(src_idx), 32'd1);
      chk("hold_nogr", 32'(grant), 32'd0);
    end
    hold = 1'b0;
    step();
    chk("hold_wrap_src", 32'(src_idx), 32'd0);
    chk("hold_wrap_gr",  32'(grant), 32'h1);

    // Preemption by source 0, then reset mid-dwell.
    do_reset();
    req = 4'b0100;
    step();
    chk("pre_src2", 32'(src_idx), 32'd2);
    step();
    step();
    req = 4'b0101;
    step();
    chk("pre_src0", 32'(src_idx), 32'd0);
    chk("pre_gr0",  32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_num",   32'(binary_num), 32'd0);
    chk("rst_src",   32'(src_idx), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;

    // Randomized traffic; the model checks every cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) req = req ^ (N'(1) << $urandom_range(0, N - 1));
      hold = ($urandom_range(0, 15) < 3);
      if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
